// File: rtl/if_prefetch_queue_if.sv
// Fetch-side and decode-side signals of the instruction prefetch queue.
// master = the prefetch queue, slave = the memory/decode environment.
interface if_prefetch_queue_if #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               freeze;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_addr;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               valid_out;
    logic [ADDR_W-1:0]  pc_out;
    logic [INSTR_W-1:0] instr_out;
    logic [CNT_W-1:0]   count;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
        output imem_req, imem_addr, valid_out, pc_out, instr_out, count
    );

    modport slave (
        output freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
        input  imem_req, imem_addr, valid_out, pc_out, instr_out, count
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: DEPTH-entry {PC, instr} FIFO fed over a req/ack fetch port.
// Optional same-cycle response bypass to decode is enabled by defining IF_PFQ_BYPASS_EN.
module if_prefetch_queue #(
    parameter int                INSTR_W  = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    if_prefetch_queue_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // S_IDLE: waiting for free space | S_REQ: fetch outstanding | S_DROP: stale fetch after redirect
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t             r_state;
    logic               r_imem_req;
    logic [ADDR_W-1:0]  r_req_pc;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];

    logic               w_ack_ok;
    logic               w_q_valid;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_reissue;
    logic               w_space;

    assign w_ack_ok  = (r_state == S_REQ) && bus.imem_ack && !bus.branch_taken;
    assign w_q_valid = (r_count != '0);

`ifdef IF_PFQ_BYPASS_EN
    // An empty queue hands the response straight to decode; it is only stored if decode is frozen.
    assign w_bypass = w_ack_ok && !w_q_valid;
    assign w_push   = w_ack_ok && !(w_bypass && !bus.freeze);
`else
    assign w_bypass = 1'b0;
    assign w_push   = w_ack_ok;
`endif

    assign w_pop       = w_q_valid && !bus.freeze;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_reissue   = (w_count_nxt != CNT_W'(DEPTH));
    assign w_space     = (r_count != CNT_W'(DEPTH));

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_req_pc;
    assign bus.count     = r_count;
    assign bus.valid_out = w_q_valid || w_bypass;
    assign bus.pc_out    = w_q_valid ? r_mem_pc[r_head]
                         : (w_bypass ? r_req_pc : '0);
    assign bus.instr_out = w_q_valid ? r_mem_instr[r_head]
                         : (w_bypass ? bus.imem_rdata : '0);

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_pc[r_tail]    <= r_req_pc;
            r_mem_instr[r_tail] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_imem_req <= 1'b0;
            r_req_pc   <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (bus.branch_taken) begin
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_fetch_pc <= bus.branch_addr;
            end else begin
                if (w_push) r_tail <= r_tail + PTR_W'(1);
                if (w_pop)  r_head <= r_head + PTR_W'(1);
                r_count <= w_count_nxt;
            end

            case (r_state)
                S_IDLE: begin
                    if (!bus.branch_taken && w_space) begin
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
                    end
                end
                S_REQ: begin
                    if (bus.branch_taken) begin
                        if (bus.imem_ack) begin
                            r_state    <= S_IDLE;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_state    <= S_DROP;
                        end
                    end else if (bus.imem_ack) begin
                        if (w_reissue) begin
                            r_req_pc   <= r_fetch_pc;
                            r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
                        end else begin
                            r_state    <= S_IDLE;
                            r_imem_req <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (bus.imem_ack) begin
                        r_state    <= S_IDLE;
                        r_imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed table-driven bench for if_prefetch_queue (DEPTH=4, PC_STEP=4, RESET_PC=0).
module tb_if_prefetch_queue;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    if_prefetch_queue_if #(.INSTR_W(32), .ADDR_W(32), .DEPTH(4)) bus ();

    if_prefetch_queue #(
        .INSTR_W(32), .ADDR_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[15:0]} ^ 32'h0000_5A5A;
    endfunction

    function automatic void add(input logic rst_i, input logic frz_i, input logic br_i,
                                input logic [31:0] baddr_i, input logic ack_i,
                                input logic req_i, input logic [31:0] addr_i,
                                input logic valid_i, input logic [31:0] pc_i,
                                input logic [2:0] cnt_i);
        vec_t v;
        v.rst = rst_i; v.frz = frz_i; v.br = br_i; v.baddr = baddr_i; v.ack = ack_i;
        v.req = req_i; v.addr = addr_i; v.valid = valid_i; v.pc = pc_i; v.cnt = cnt_i;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    initial begin
        int          k;
        int          cyc;
        logic [31:0] exp_instr;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.freeze = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr = '0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;

`ifndef IF_PFQ_BYPASS_EN
        // rst fz br baddr ack | req addr valid pc cnt
        add(0,0,0,0,0,       0,32'h0,  0,32'h0,  0);  // reset state
        add(0,0,0,0,0,       1,32'h0,  0,32'h0,  0);
        add(0,0,0,0,1,       1,32'h0,  0,32'h0,  0);
        add(0,0,0,0,0,       1,32'h4,  1,32'h0,  1);
        add(0,0,0,0,1,       1,32'h4,  0,32'h0,  0);
        add(0,0,0,0,0,       1,32'h8,  1,32'h4,  1);
        add(0,0,0,0,1,       1,32'h8,  0,32'h0,  0);
        add(0,0,0,0,0,       1,32'hC,  1,32'h8,  1);
        add(0,0,0,0,1,       1,32'hC,  0,32'h0,  0);
        add(0,0,0,0,0,       1,32'h10, 1,32'hC,  1);
        add(1,0,0,0,0,       1,32'h10, 0,32'h0,  0);  // reset mid-request
        add(0,0,0,0,0,       0,32'h0,  0,32'h0,  0);
        add(0,0,0,0,1,       1,32'h0,  0,32'h0,  0);  // zero-latency fill under freeze
        add(0,1,0,0,1,       1,32'h4,  1,32'h0,  1);
        add(0,1,0,0,1,       1,32'h8,  1,32'h0,  2);
        add(0,1,0,0,1,       1,32'hC,  1,32'h0,  3);
        add(0,1,0,0,0,       0,32'hC,  1,32'h0,  4);
        add(0,1,0,0,0,       0,32'hC,  1,32'h0,  4);
        add(0,0,0,0,0,       0,32'hC,  1,32'h0,  4);
        add(0,1,0,0,0,       0,32'hC,  1,32'h4,  3);
        add(0,1,0,0,0,       1,32'h10, 1,32'h4,  3);
        add(0,0,0,0,1,       1,32'h10, 1,32'h4,  3);  // push+pop, tail wraps
        add(0,0,0,0,1,       1,32'h14, 1,32'h8,  3);
        add(0,0,0,0,0,       1,32'h18, 1,32'hC,  3);
        add(0,0,0,0,0,       1,32'h18, 1,32'h10, 2);
        add(0,0,0,0,0,       1,32'h18, 1,32'h14, 1);
        add(0,0,0,0,0,       1,32'h18, 0,32'h0,  0);
        add(0,0,1,32'h100,0, 1,32'h18, 0,32'h0,  0);  // redirect while request pending
        add(0,0,0,0,0,       1,32'h18, 0,32'h0,  0);
        add(0,0,0,0,0,       1,32'h18, 0,32'h0,  0);
        add(0,0,0,0,1,       1,32'h18, 0,32'h0,  0);
        add(0,0,0,0,0,       0,32'h18, 0,32'h0,  0);
        add(0,0,0,0,1,       1,32'h100,0,32'h0,  0);
        add(0,0,0,0,0,       1,32'h104,1,32'h100,1);
        add(0,1,0,0,0,       1,32'h104,0,32'h0,  0);
        add(0,1,0,0,1,       1,32'h104,0,32'h0,  0);
        add(0,1,0,0,0,       1,32'h108,1,32'h104,1);
        add(0,0,1,32'h200,1, 1,32'h108,1,32'h104,1);  // redirect with ack and pop
        add(0,0,0,0,0,       0,32'h108,0,32'h0,  0);
        add(0,0,0,0,1,       1,32'h200,0,32'h0,  0);
        add(0,0,0,0,0,       1,32'h204,1,32'h200,1);
        add(0,0,0,0,0,       1,32'h204,0,32'h0,  0);
        add(0,0,1,32'h300,0, 1,32'h204,0,32'h0,  0);  // second redirect during drop
        add(0,0,1,32'h400,0, 1,32'h204,0,32'h0,  0);
        add(0,0,0,0,1,       1,32'h204,0,32'h0,  0);
        add(0,0,0,0,0,       0,32'h204,0,32'h0,  0);
        add(0,0,0,0,0,       1,32'h400,0,32'h0,  0);
`else
        add(0,0,1,32'h20,0,  0,32'h0,  0,32'h0,  0);
        add(0,0,0,0,0,       0,32'h0,  0,32'h0,  0);
        add(0,0,0,0,1,       1,32'h20, 1,32'h20, 0);  // bypass, consumed
        add(0,0,0,0,0,       1,32'h24, 0,32'h0,  0);
        add(0,1,0,0,1,       1,32'h24, 1,32'h24, 0);  // bypass under freeze, stored
        add(0,1,0,0,0,       1,32'h28, 1,32'h24, 1);
        add(0,0,0,0,1,       1,32'h28, 1,32'h24, 1);
        add(0,0,0,0,0,       1,32'h2C, 1,32'h28, 1);
        add(0,0,0,0,0,       1,32'h2C, 0,32'h0,  0);
        add(0,0,1,32'h80,1,  1,32'h2C, 0,32'h0,  0);  // redirect blocks bypass
        add(0,0,0,0,0,       0,32'h2C, 0,32'h0,  0);
        add(0,0,0,0,1,       1,32'h80, 1,32'h80, 0);
`endif

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst              = vecs[i].rst;
            bus.freeze       = vecs[i].frz;
            bus.branch_taken = vecs[i].br;
            bus.branch_addr  = vecs[i].baddr;
            bus.imem_ack     = vecs[i].ack;
            bus.imem_rdata   = word(vecs[i].addr);
            #1;
            exp_instr = vecs[i].valid ? word(vecs[i].pc) : 32'h0;
            chk("imem_req",  i, {31'b0, bus.imem_req},  {31'b0, vecs[i].req});
            chk("imem_addr", i, bus.imem_addr,          vecs[i].addr);
            chk("valid_out", i, {31'b0, bus.valid_out}, {31'b0, vecs[i].valid});
            chk("pc_out",    i, bus.pc_out,             vecs[i].pc);
            chk("instr_out", i, bus.instr_out,          exp_instr);
            chk("count",     i, {29'b0, bus.count},     {29'b0, vecs[i].cnt});
        end

        // Streaming run with a zero-latency memory: first four heads must be 0,4,8,C.
        @(negedge clk);
        rst = 1'b1;
        bus.freeze = 1'b0;
        bus.branch_taken = 1'b0;
        bus.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            @(negedge clk);
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = word(bus.imem_addr);
            #1;
            if (bus.valid_out) begin
                chk("seq_pc",    k, bus.pc_out,    32'(k * 4));
                chk("seq_instr", k, bus.instr_out, word(32'(k * 4)));
                k++;
            end
            cyc++;
        end
        if (k < 4) begin
            checks++;
            failures++;
            $display("FAIL seq_timeout: got %0d valid beats want 4", k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
